usb_crc16_tx_ctrl: RTL and testbench
====================================

// Module: usb_crc16_tx_ctrl
// PURPOSE
// - Sequences CRC16 generation for the USB transmitter data path.
// - Accepts packet bytes over a valid/ready handshake and serializes each byte LSB-first to the
//   bit encoder over a second valid/ready handshake, updating the CRC16 remainder as each bit leaves.
// - After the last byte, appends the complemented remainder, MSB-first.
// - Sits between the packet byte source and the NRZI/bit-stuff stage; the encoder may stall via bit_ready.
// PARAMETERS
// - DATA_W     8        byte width; bits per byte
// - CRC_W      16       remainder width
// - POLY       16'h8005 CRC16 generator polynomial, x^16 term implicit
// - INIT       16'hFFFF remainder value loaded on start
// - MAX_BYTES  1024     max payload bytes; exceeding sets overflow
// PORTS
// - clk         in   1       system clock, rising edge
// - rst         in   1       asynchronous reset, active-high
// - start       in   1       1-cycle pulse; begins packet; ignored while busy
// - zlp         in   1       sampled with start; 1 = zero-length packet, no bytes taken
// - abort       in   1       synchronous cancel; returns to IDLE next edge
// - byte_in     in   DATA_W  payload byte
// - byte_valid  in   1       byte_in/byte_last valid
// - byte_last   in   1       final byte of packet
// - byte_ready  out  1       controller accepts byte this cycle
// - bit_out     out  1       serial bit to encoder
// - bit_valid   out  1       bit_out valid
// - bit_ready   in   1       encoder consumes bit_out this cycle
// - crc_out     out  CRC_W   live CRC remainder, not complemented
// - byte_count  out  11      bytes accepted this packet, saturating at 2047
// - busy        out  1       high in any state except IDLE
// - done        out  1       1-cycle pulse after the last CRC bit is consumed
// - overflow    out  1       sticky per packet; set when byte_count exceeds MAX_BYTES
// BEHAVIOUR
// - Reset values: state=IDLE; byte_ready, bit_valid, bit_out, busy, done, overflow = 0;
//   crc_out=INIT; byte_count=0.
// - States: IDLE, WAIT_BYTE, SHIFT, CRC, DONE.
// - IDLE
//   - start & !zlp: crc<=INIT, byte_count<=0, overflow<=0; go WAIT_BYTE.
//   - start & zlp: crc<=INIT, crc_sreg<=~INIT; go CRC.
// - WAIT_BYTE
//   - byte_ready=1.
//   - On byte_valid: latch byte into sreg and byte_last into last_q; byte_count++; bit_idx<=0; go SHIFT.
// - SHIFT
//   - bit_valid=1; bit_out=sreg[0]. Hold all state while !bit_ready.
//   - On bit_ready: fb=bit_out^crc[15]; crc<={crc[14:0],0}^(fb?POLY:0); sreg>>=1; bit_idx++.
//   - Exit: bit_idx==DATA_W-1 & bit_ready -> CRC if last_q, else WAIT_BYTE.
//     When entering CRC, load crc_sreg<=~crc_next, where crc_next is the updated remainder.
// - CRC
//   - bit_valid=1; bit_out=crc_sreg[15]; shift crc_sreg left on bit_ready.
//   - After the 16th consumed bit, go DONE. crc_out is held.
// - DONE
//   - done=1 for one cycle; busy=1; go IDLE.
// - Latency: start -> byte_ready one cycle later. Byte accept -> first bit_valid the next cycle.
// - No bubbles: with bit_ready held high, bits stream back-to-back across the SHIFT->CRC boundary.
//   Between bytes there is exactly one WAIT_BYTE cycle, even when byte_valid is already high.
// - bit_out is stable while bit_valid & !bit_ready.
// - byte_ready=0 outside WAIT_BYTE.
// - abort
//   - Any state -> IDLE next edge; done not pulsed; crc_out keeps its value.
//   - abort has priority over start, byte and bit handshakes in the same cycle.
// - start while busy: ignored, no effect.
// - byte_count: saturates at 2047. overflow is set once byte_count > MAX_BYTES;
//   the packet still completes.
// - Async rst mid-packet: all outputs return to reset values immediately.
// TESTING
// - 1. Single 0x00 byte (last=1), bit_ready=1: bits 00000000, then CRC 0000_0010_1111_1101
//   (0x02FD MSB-first); crc_out=0xFD02; done 1 cycle after the 24th bit.
// - 2. start with zlp=1: exactly 16 bits of 0 (~0xFFFF); byte_ready never asserted; done pulses.
// - 3. Two bytes 0xA5, 0x3C, bit_ready toggling 1/0 each cycle:
//   - bit_out held during stalls;
//   - serial stream matches the reference CRC model;
//   - byte_count=2.
// - 4. abort asserted mid-SHIFT (bit 3 of byte 1): IDLE next cycle, bit_valid=0, no done;
//   a new start then produces correct CRC from INIT.
// - 5. start pulsed during CRC state: ignored; stream is unchanged; a single done.
// - 6. 1025 bytes, MAX_BYTES=1024: overflow rises when byte 1025 is accepted; packet completes;
//   byte_count=1025.

Source files
------------

// File: rtl/usb_crc16_tx_ctrl.sv
// USB transmit CRC16 sequencer: serializes packet bytes LSB-first to the bit encoder,
// then appends the complemented CRC16 remainder MSB-first.
module usb_crc16_tx_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CRC_W     = 16,
  parameter logic [CRC_W-1:0] POLY = 16'h8005,
  parameter logic [CRC_W-1:0] INIT = 16'hFFFF,
  parameter int unsigned MAX_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              zlp,
  input  logic              abort,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic [10:0]       byte_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CIDX_W = $clog2(CRC_W);

  typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, CRC, DONE} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   crc_sreg_q, crc_sreg_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CIDX_W-1:0]  crc_idx_q, crc_idx_d;
  logic               last_q, last_d;
  logic [10:0]        cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [CRC_W-1:0]   crc_step;
  logic [10:0]        cnt_inc;

  // Remainder after shifting out the current LSB of the byte register.
  assign crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ ((sreg_q[0] ^ crc_q[CRC_W-1]) ? POLY : '0);
  assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= INIT;
      crc_sreg_q <= '0;
      sreg_q     <= '0;
      bit_idx_q  <= '0;
      crc_idx_q  <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      crc_sreg_q <= crc_sreg_d;
      sreg_q     <= sreg_d;
      bit_idx_q  <= bit_idx_d;
      crc_idx_q  <= crc_idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    crc_sreg_d = crc_sreg_q;
    sreg_d     = sreg_q;
    bit_idx_d  = bit_idx_q;
    crc_idx_d  = crc_idx_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    // abort wins over every handshake: nothing but the state moves.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          crc_d = INIT;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (zlp) begin
            crc_sreg_d = ~INIT;
            crc_idx_d  = '0;
            state_d    = CRC;
          end else begin
            state_d = WAIT_BYTE;
          end
        end
        WAIT_BYTE: if (byte_valid) begin
          sreg_d    = byte_in;
          last_d    = byte_last;
          cnt_d     = cnt_inc;
          bit_idx_d = '0;
          if (32'(cnt_inc) > MAX_BYTES) ovf_d = 1'b1;
          state_d   = SHIFT;
        end
        SHIFT: if (bit_ready) begin
          crc_d     = crc_step;
          sreg_d    = sreg_q >> 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            if (last_q) begin
              crc_sreg_d = ~crc_step;
              crc_idx_d  = '0;
              state_d    = CRC;
            end else begin
              state_d = WAIT_BYTE;
            end
          end
        end
        CRC: if (bit_ready) begin
          crc_sreg_d = {crc_sreg_q[CRC_W-2:0], 1'b0};
          crc_idx_d  = crc_idx_q + CIDX_W'(1);
          if (crc_idx_q == CIDX_W'(CRC_W - 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign byte_ready = (state_q == WAIT_BYTE);
  assign bit_valid  = (state_q == SHIFT) || (state_q == CRC);
  assign bit_out    = (state_q == SHIFT) ? sreg_q[0] :
                      (state_q == CRC)   ? crc_sreg_q[CRC_W-1] : 1'b0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign crc_out    = crc_q;
  assign byte_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_usb_crc16_tx_ctrl.sv
// Randomized bench for usb_crc16_tx_ctrl against a bit-stream CRC16 reference model.
module tb_usb_crc16_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, zlp, abort;
  logic [7:0]  byte_in;
  logic        byte_valid, byte_last, byte_ready;
  logic        bit_out, bit_valid, bit_ready;
  logic [15:0] crc_out;
  logic [10:0] byte_count;
  logic        busy, done, overflow;

  usb_crc16_tx_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .zlp(zlp), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_ready(byte_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .crc_out(crc_out), .byte_count(byte_count),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // bit_ready driver: 0 = always ready, 1 = toggle, 2 = random
  int   rdy_mode = 0;
  logic tog = 1'b0;
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (rdy_mode)
      0:       bit_ready = 1'b1;
      1:       bit_ready = tog;
      default: bit_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: records consumed bits, done pulses, byte_ready cycles and stall stability.
  logic got_q[$];
  int   cyc = 0, done_cnt = 0, br_cnt = 0, stall_viol = 0;
  int   last_bit_cyc = 0, done_cyc = 0;
  logic stall_pend = 1'b0, stall_bit = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bit_valid && bit_ready && !abort && !rst) begin
      got_q.push_back(bit_out);
      last_bit_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (byte_ready) br_cnt <= br_cnt + 1;
    if (stall_pend && bit_valid && (bit_out !== stall_bit)) stall_viol <= stall_viol + 1;
    stall_pend <= bit_valid && !bit_ready && !abort;
    stall_bit  <= bit_out;
  end

  // Reference model: CRC16 as polynomial division, one message bit at a time.
  logic exp_q[$];
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic [16:0] sh;
    sh = 17'(c) * 2;
    return sh[15:0] ^ (((b ^ c[15]) == 1'b1) ? 16'h8005 : 16'h0000);
  endfunction

  function automatic logic [15:0] build_exp(input logic [7:0] d[$]);
    logic [15:0] c, r;
    c = 16'hFFFF;
    exp_q.delete();
    foreach (d[k])
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(d[k][i]);
        c = crc_bit(c, d[k][i]);
      end
    r = ~c;
    for (int i = 15; i >= 0; i--) exp_q.push_back(r[i]);
    return c;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] data[$], input bit z,
                         input int mode, input bit start_in_crc);
    int base, dn0, br0, sv0, bad, to;
    logic [15:0] ecrc;
    rdy_mode = mode;
    base = got_q.size(); dn0 = done_cnt; br0 = br_cnt; sv0 = stall_viol;
    start = 1'b1; zlp = z;
    tick();
    start = 1'b0; zlp = 1'b0;
    if (!z) begin
      chk({tag, "_start_lat"}, 32'(byte_ready), 1);
      foreach (data[i]) begin
        repeat ($urandom_range(0, 2)) tick();
        byte_in = data[i]; byte_last = (i == data.size() - 1); byte_valid = 1'b1;
        to = 0;
        while (to < 1000) begin
          @(negedge clk);
          if (byte_ready) break;
          to++;
        end
        if (to >= 1000) begin
          chk({tag, "_byte_timeout"}, 0, 1);
          byte_valid = 1'b0;
          return;
        end
        tick();
        byte_valid = 1'b0;
        if (i == 0) chk({tag, "_first_bit_lat"}, 32'(bit_valid), 1);
        if (i == 1023) chk({tag, "_ovf_at_1024"}, 32'(overflow), 0);
        if (i == 1024) chk({tag, "_ovf_at_1025"}, 32'(overflow), 1);
      end
    end
    if (start_in_crc) begin
      to = 0;
      while ((got_q.size() - base < data.size() * 8 + 5) && to < 200) begin
        tick(); to++;
      end
      start = 1'b1; zlp = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0; zlp = 1'b0;
    end
    to = 0;
    while (to < 30000) begin
      @(negedge clk);
      if (done) break;
      to++;
    end
    if (to >= 30000) begin
      chk({tag, "_done_timeout"}, 0, 1);
      return;
    end
    tick();
    ecrc = build_exp(data);
    chk({tag, "_nbits"}, got_q.size() - base, exp_q.size());
    bad = 0;
    foreach (exp_q[i])
      if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) bad++;
    chk({tag, "_bit_errs"}, bad, 0);
    chk({tag, "_crc_out"}, 32'(crc_out), 32'(ecrc));
    chk({tag, "_done_cnt"}, done_cnt - dn0, 1);
    chk({tag, "_done_lat"}, done_cyc - last_bit_cyc, 1);
    chk({tag, "_stall_hold"}, stall_viol - sv0, 0);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    if (z) chk({tag, "_zlp_no_ready"}, br_cnt - br0, 0);
    else begin
      chk({tag, "_byte_count"}, 32'(byte_count), data.size());
      chk({tag, "_overflow"}, 32'(overflow), 32'(data.size() > 1024));
    end
  endtask

  logic [7:0] pkt[$];
  logic [15:0] c3;
  int to, dn0;

  initial begin
    rst = 1'b1; start = 1'b0; zlp = 1'b0; abort = 1'b0;
    byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_crc", 32'(crc_out), 32'hFFFF);
    chk("rst_count", 32'(byte_count), 0);
    rst = 1'b0;
    tick();

    // single zero byte: known residue
    pkt = '{8'h00};
    run_pkt("zero", pkt, 1'b0, 0, 1'b0);
    chk("zero_crc_const", 32'(crc_out), 32'hFD02);

    pkt.delete();
    run_pkt("zlp", pkt, 1'b1, 0, 1'b0);

    pkt = '{8'hA5, 8'h3C};
    run_pkt("two_toggle", pkt, 1'b0, 1, 1'b0);

    // abort during bit 3 of the first byte
    rdy_mode = 0; dn0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    byte_in = 8'hA5; byte_last = 1'b0; byte_valid = 1'b1;
    tick(); byte_valid = 1'b0;
    to = got_q.size();
    for (int k = 0; k < 50 && (got_q.size() - to) != 3; k++) tick();
    chk("abort_reach_bit3", got_q.size() - to, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    c3 = 16'hFFFF;
    for (int i = 0; i < 3; i++) c3 = crc_bit(c3, 1'(8'hA5 >> i));
    chk("abort_busy", 32'(busy), 0);
    chk("abort_bit_valid", 32'(bit_valid), 0);
    chk("abort_crc_kept", 32'(crc_out), 32'(c3));
    repeat (4) tick();
    chk("abort_no_done", done_cnt - dn0, 0);
    pkt = '{8'h12, 8'h34, 8'h56};
    run_pkt("after_abort", pkt, 1'b0, 2, 1'b0);

    pkt = '{8'hDE, 8'hAD};
    run_pkt("start_in_crc", pkt, 1'b0, 0, 1'b1);

    for (int p = 0; p < 4; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 12)) pkt.push_back(8'($urandom));
      run_pkt($sformatf("rand%0d", p), pkt, 1'b0, $urandom_range(0, 2), 1'b0);
    end

    pkt.delete();
    repeat (1025) pkt.push_back(8'($urandom));
    run_pkt("ovf1025", pkt, 1'b0, 0, 1'b0);

    // async reset in the middle of SHIFT
    rdy_mode = 2;
    start = 1'b1; tick(); start = 1'b0;
    byte_in = 8'h55; byte_last = 1'b1; byte_valid = 1'b1;
    tick(); byte_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_bit_valid", 32'(bit_valid), 0);
    chk("arst_crc", 32'(crc_out), 32'hFFFF);
    chk("arst_count", 32'(byte_count), 0);
    tick();
    rst = 1'b0;
    tick();
    pkt = '{8'h80};
    run_pkt("after_arst", pkt, 1'b0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
